// File: rtl/vpu_pkg.sv
// vpu_pkg: opcode and state types plus default parameter constants for vpu_exec_pipe
package vpu_pkg;
  localparam int VPU_LANE_CNT      = 8;
  localparam int VPU_OPERAND_WIDTH = 16;
  localparam int VPU_SRC_CNT       = 2;
  localparam int VPU_OUT_DEPTH     = 4;
  localparam int VPU_DELAY_WIDTH   = 4;
  typedef enum logic [2:0] {
    ADD     = 3'd0,
    SUB     = 3'd1,
    MAX     = 3'd2,
    MIN     = 3'd3,
    RED_SUM = 3'd4,
    RED_MAX = 3'd5
  } vpu_exec_op_t;
  typedef enum logic {IDLE, EXEC} vpu_state_t;
  function automatic logic is_red(input vpu_exec_op_t op);
    return op == RED_SUM || op == RED_MAX;
  endfunction
endpackage

// File: rtl/vpu_exec_out_fifo.sv
// vpu_exec_out_fifo: result FIFO with same-cycle push/pop and zeroed output when empty
module vpu_exec_out_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    valid_o = cnt_q != '0;
    full_o  = cnt_q == (AW+1)'(DEPTH);
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && valid_o;
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_ok ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    dout_o  = valid_o ? mem_q[rptr_q] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/vpu_exec_pipe.sv
// vpu_exec_pipe: multi-cycle vector lane/reduction unit with result FIFO; define VPU_EXEC_PIPE_LANE_MASK_EN for lane_mask_i
module vpu_exec_pipe
  import vpu_pkg::*;
#(
  parameter int LANE_CNT      = VPU_LANE_CNT,
  parameter int OPERAND_WIDTH = VPU_OPERAND_WIDTH,
  parameter int SRC_CNT       = VPU_SRC_CNT,
  parameter int OUT_DEPTH     = VPU_OUT_DEPTH,
  parameter int DELAY_WIDTH   = VPU_DELAY_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  vpu_exec_op_t                               op_func_i,
  input  logic [DELAY_WIDTH-1:0]                     delay_i,
  input  logic [SRC_CNT-1:0][LANE_CNT*OPERAND_WIDTH-1:0] operand_i,
`ifdef VPU_EXEC_PIPE_LANE_MASK_EN
  input  logic [LANE_CNT-1:0]                        lane_mask_i,
`endif
  output logic                                       dout_valid_o,
  input  logic                                       dout_ready_i,
  output logic [LANE_CNT*OPERAND_WIDTH-1:0]          dout_o,
  output logic                                       err_o,
  output logic                                       busy_o
);
  localparam int W  = OPERAND_WIDTH;
  localparam int LW = LANE_CNT*W;
  vpu_state_t state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  vpu_exec_op_t op_q, op_d;
  logic [SRC_CNT-1:0][LW-1:0] opnd_q, opnd_d;
  logic [LANE_CNT-1:0] lane_en;
  logic accept, push, fifo_full, err;
  logic [LW-1:0] res;
  logic [LW:0] fifo_dout;
  logic [W-1:0] a, b, lr, sum, mx;
  logic gt;
`ifdef VPU_EXEC_PIPE_LANE_MASK_EN
  logic [LANE_CNT-1:0] mask_q, mask_d;
  assign mask_d  = accept ? lane_mask_i : mask_q;
  assign lane_en = mask_q;
  always_ff @(posedge clk) mask_q <= rst ? '0 : mask_d;
`else
  assign lane_en = '1;
`endif
  assign req_ready_o = !rst && state_q == IDLE && !fifo_full;
  assign busy_o      = state_q != IDLE;
  always_comb begin
    accept  = req_valid_i && req_ready_o;
    push    = state_q == EXEC && cnt_q == DELAY_WIDTH'(1);
    state_d = accept ? EXEC : push ? IDLE : state_q;
    cnt_d   = accept ? (delay_i == '0 ? DELAY_WIDTH'(1) : delay_i)
            : state_q == EXEC ? cnt_q - DELAY_WIDTH'(1) : cnt_q;
    op_d    = accept ? op_func_i : op_q;
    opnd_d  = accept ? operand_i : opnd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= ADD;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
    end
  end
  // Disabled lanes pass src0 through and drop out of reductions (0 for sum, most-negative for max).
  always_comb begin
    res = '0;
    err = 1'b0;
    sum = '0;
    mx  = {1'b1, {(W-1){1'b0}}};
    a   = '0;
    b   = '0;
    lr  = '0;
    gt  = 1'b0;
    for (int k = 0; k < LANE_CNT; k++) begin
      a  = opnd_q[0][k*W +: W];
      b  = opnd_q[1][k*W +: W];
      gt = $signed(a) > $signed(b);
      lr = op_q == ADD ? a + b : op_q == SUB ? a - b : op_q == MAX ? (gt ? a : b) : (gt ? b : a);
      res[k*W +: W] = lane_en[k] ? lr : a;
      sum = sum + (lane_en[k] ? a : '0);
      mx  = (lane_en[k] && $signed(a) > $signed(mx)) ? a : mx;
    end
    if (is_red(op_q)) res = {{(LW-W){1'b0}}, op_q == RED_SUM ? sum : mx};
    else if (!(op_q inside {ADD, SUB, MAX, MIN})) begin
      res = '0;
      err = 1'b1;
    end
  end
  vpu_exec_out_fifo #(.WIDTH(LW+1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({err, res}),
    .pop_i   (dout_ready_i),
    .dout_o  (fifo_dout),
    .valid_o (dout_valid_o),
    .full_o  (fifo_full)
  );
  assign dout_o = fifo_dout[LW-1:0];
  assign err_o  = fifo_dout[LW];
endmodule

// File: tb/tb_vpu_exec_pipe.sv
// tb_vpu_exec_pipe: directed self-checking bench for vpu_exec_pipe with default parameters
module tb_vpu_exec_pipe;
  import vpu_pkg::*;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, dout_valid, dout_ready, err, busy;
  vpu_exec_op_t op_func;
  logic [3:0] delay;
  logic [1:0][127:0] operand;
  logic [127:0] dout, s;
  logic [7:0] mask;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  vpu_exec_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_func_i    (op_func),
    .delay_i      (delay),
    .operand_i    (operand),
`ifdef VPU_EXEC_PIPE_LANE_MASK_EN
    .lane_mask_i  (mask),
`endif
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .dout_o       (dout),
    .err_o        (err),
    .busy_o       (busy)
  );
  function automatic logic [127:0] rep(input logic [15:0] other, input logic [15:0] l0);
    return {{7{other}}, l0};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input vpu_exec_op_t op, input logic [3:0] d, input logic [127:0] s0, input logic [127:0] s1);
    int n = 0;
    op_func = op;
    delay = d;
    operand[0] = s0;
    operand[1] = s1;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("issue_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    op_func = vpu_exec_op_t'(3'd7);
    delay = 4'hF;
    operand = '1;
  endtask
  task automatic result(input string tag, input logic [127:0] exp, input logic exp_err);
    int n = 0;
    while (!dout_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, dout_valid, 1);
    chk({tag, "_dout"}, dout, exp);
    chk({tag, "_err"}, err, exp_err);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    op_func = ADD;
    delay = '0;
    operand = '0;
    dout_ready = 1'b1;
    mask = '1;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    issue(ADD, 4'd3, rep(16'h0010, 16'hFFFF), rep(16'h0020, 16'h0002));
    chk("add_busy", busy, 1);
    chk("add_v0", dout_valid, 0);
    chk("add_dout_gated", dout, 0);
    tick();
    chk("add_v1", dout_valid, 0);
    tick();
    chk("add_v2", dout_valid, 0);
    tick();
    chk("add_v3", dout_valid, 1);
    chk("add_dout", dout, rep(16'h0030, 16'h0001));
    chk("add_err", err, 0);
    chk("add_idle", busy, 0);
    tick();
    chk("add_popped", dout_valid, 0);
    issue(MAX, 4'd1, rep(16'h7FFF, 16'h8000), rep(16'hFFFF, 16'h0001));
    result("max", rep(16'h7FFF, 16'h0001), 1'b0);
    issue(MIN, 4'd1, rep(16'h7FFF, 16'h8000), rep(16'hFFFF, 16'h0001));
    result("min", rep(16'hFFFF, 16'h8000), 1'b0);
    issue(SUB, 4'd2, rep(16'h0000, 16'h0000), rep(16'h0001, 16'h0001));
    result("sub_wrap", rep(16'hFFFF, 16'hFFFF), 1'b0);
    issue(RED_SUM, 4'd1, {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, '0);
    result("red_sum", rep(16'h0000, 16'd36), 1'b0);
    issue(RED_SUM, 4'd1, rep(16'h4000, 16'h4000), '0);
    result("red_sum_wrap", rep(16'h0000, 16'h0000), 1'b0);
    s = rep(16'hFFFF, 16'hFFFE);
    s[5*16 +: 16] = 16'h0005;
    issue(RED_MAX, 4'd1, s, '0);
    result("red_max", rep(16'h0000, 16'h0005), 1'b0);
    issue(ADD, 4'd0, rep(16'h0001, 16'h0001), rep(16'h0001, 16'h0001));
    chk("d0_v0", dout_valid, 0);
    tick();
    chk("d0_v1", dout_valid, 1);
    chk("d0_dout", dout, rep(16'h0002, 16'h0002));
    tick();
    issue(ADD, 4'd1, rep(16'h0001, 16'h0001), rep(16'h0001, 16'h0001));
    chk("d1_v0", dout_valid, 0);
    tick();
    chk("d1_v1", dout_valid, 1);
    chk("d1_dout", dout, rep(16'h0002, 16'h0002));
    tick();
    issue(vpu_exec_op_t'(3'd6), 4'd2, rep(16'h0001, 16'h0001), rep(16'h0001, 16'h0001));
    result("ill6", '0, 1'b1);
    issue(vpu_exec_op_t'(3'd7), 4'd1, rep(16'h0003, 16'h0003), rep(16'h0001, 16'h0001));
    result("ill7", '0, 1'b1);
    chk("ill_err_gated", err, 0);
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue(ADD, 4'd1, rep(16'h0000, 16'(i)), '0);
    tick();
    chk("full_ready", req_ready, 0);
    chk("full_busy", busy, 0);
    req_valid = 1'b1;
    op_func = ADD;
    delay = 4'd1;
    operand[0] = rep(16'h0000, 16'd5);
    operand[1] = '0;
    repeat (3) tick();
    chk("full_hold_busy", busy, 0);
    chk("full_hold_ready", req_ready, 0);
    chk("full_head", dout, rep(16'h0000, 16'd1));
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("pop_reenable", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("fifth_busy", busy, 1);
    tick();
    dout_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("order_valid", dout_valid, 1);
      chk("order_dout", dout, rep(16'h0000, 16'(i)));
      tick();
    end
    chk("drained", dout_valid, 0);
    dout_ready = 1'b0;
    issue(ADD, 4'd1, rep(16'h0000, 16'd7), '0);
    tick();
    chk("held_entry", dout_valid, 1);
    issue(ADD, 4'd8, rep(16'h0000, 16'd9), '0);
    tick();
    chk("midexec_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_err", err, 0);
    repeat (12) tick();
    chk("midrst_no_stale", dout_valid, 0);
    chk("midrst_idle", busy, 0);
`ifdef VPU_EXEC_PIPE_LANE_MASK_EN
    dout_ready = 1'b1;
    mask = 8'h0F;
    issue(SUB, 4'd1, rep(16'd5, 16'd5), rep(16'd3, 16'd3));
    mask = 8'h00;
    result("mask_sub", {{4{16'd5}}, {4{16'd2}}}, 1'b0);
    mask = 8'h0F;
    issue(RED_SUM, 4'd1, {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, '0);
    result("mask_red_sum", rep(16'h0000, 16'd10), 1'b0);
    mask = 8'h01;
    issue(RED_MAX, 4'd1, rep(16'h7FFF, 16'hFFFE), '0);
    result("mask_red_max", rep(16'h0000, 16'hFFFE), 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
